// File: rtl/loader_pkg.sv
// Shared instruction-loader definitions: FSM state encoding and frame-format constants.
// The FILL state exists only when LOADER_ZERO_FILL_EN is defined.
package loader_pkg;

  localparam int LEN_MIN        = 1;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
`ifdef LOADER_ZERO_FILL_EN
    ST_FILL  = 3'd4,
`endif
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: the first byte of a word lands in [31:24].
// word_vld_o is combinational with the byte that completes a word; no backpressure of its own.
module byte_packer
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 byte_vld_i,
  input  logic [7:0]           byte_i,
  output logic [WORD_BITS-1:0] word_o,
  output logic                 word_vld_o
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_BITS-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (byte_vld_i) begin
      cnt_d  = cnt_q + CNT_W'(1);
      word_d = {word_q[WORD_BITS-9:0], byte_i};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o     = word_q;
  assign word_vld_o = byte_vld_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Loads a LEN/payload/CHK byte frame into instruction RAM, holding the CPU in reset until a good frame lands.
// One RAM write the cycle after each 4th byte (rx_ready drops for that cycle); LOADER_ZERO_FILL_EN zero-fills the tail.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  start,
  output logic                  MemWrite,
  output logic [31:0]           MemAddress,
  output logic [31:0]           MemWriteData,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] word_count
);

  localparam int IW = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            chk_q, chk_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic [31:0]           data_hold_q, data_hold_d;

  logic        xfer, mem_we, last_word, pk_word_vld;
  logic [31:0] pk_word;

  assign xfer      = rx_valid & rx_ready;
  assign last_word = (IW'(idx_q) + IW'(1)) == IW'(len_q);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    ((state_q == ST_LEN) && xfer),
    .byte_vld_i ((state_q == ST_DATA) && xfer),
    .byte_i     (rx_data),
    .word_o     (pk_word),
    .word_vld_o (pk_word_vld)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_LEN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LEN: if (xfer) begin
        if (rx_data < 8'(LEN_MIN)) state_d = ST_ERROR;
        else                       state_d = ST_DATA;
      end
      ST_DATA:  if (pk_word_vld) state_d = ST_WRITE;
      ST_WRITE: begin
        if (last_word) state_d = ST_CHECK;
        else           state_d = ST_DATA;
      end
      ST_CHECK: if (xfer) begin
        if (rx_data == chk_q) begin
`ifdef LOADER_ZERO_FILL_EN
          state_d = ST_FILL;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_ERROR;
        end
      end
`ifdef LOADER_ZERO_FILL_EN
      // idx_q already points at word N when FILL starts; it runs to the top of memory
      ST_FILL:  if (&idx_q) state_d = ST_DONE;
`endif
      ST_DONE, ST_ERROR: if (start) state_d = ST_LEN;
      default:  state_d = ST_LEN;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    mem_we   = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      ST_LEN, ST_DATA, ST_CHECK: rx_ready = 1'b1;
      ST_WRITE: mem_we = 1'b1;
`ifdef LOADER_ZERO_FILL_EN
      ST_FILL:  mem_we = 1'b1;
`endif
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign MemWrite     = mem_we;
  assign MemAddress   = {{(32-ADDR_WIDTH-2){1'b0}}, (mem_we ? idx_q : addr_hold_q), 2'b00};
  assign MemWriteData = (state_q == ST_WRITE) ? pk_word : (mem_we ? 32'h0 : data_hold_q);
  assign word_count   = cnt_q;

  always_comb begin
    len_d       = len_q;
    chk_d       = chk_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    addr_hold_d = addr_hold_q;
    data_hold_d = data_hold_q;
    case (state_q)
      ST_LEN: if (xfer && rx_data >= 8'(LEN_MIN)) begin
        len_d = rx_data;
        chk_d = '0;
        idx_d = '0;
      end
      ST_DATA:  if (xfer) chk_d = chk_q ^ rx_data;
      ST_WRITE: begin
        idx_d = idx_q + ADDR_WIDTH'(1);
        cnt_d = cnt_q + ADDR_WIDTH'(1);
      end
`ifdef LOADER_ZERO_FILL_EN
      ST_FILL:  idx_d = idx_q + ADDR_WIDTH'(1);
`endif
      ST_DONE, ST_ERROR: if (start) cnt_d = '0;
      default: ;
    endcase
    // Address/data outputs keep the last written values between writes
    if (mem_we) begin
      addr_hold_d = idx_q;
      data_hold_d = MemWriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q       <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      len_q       <= len_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      addr_hold_q <= addr_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: frames are expanded into expected RAM writes and popped by a monitor.
// Honours LOADER_ZERO_FILL_EN so expectations match the build under test.
module tb_instruction_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, rx_valid, start;
  logic [7:0]    rx_data;
  logic          rx_ready, MemWrite, cpu_hold, done, error;
  logic [31:0]   MemAddress, MemWriteData;
  logic [AW-1:0] word_count;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  always #5 clk = ~clk;

  instruction_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .start(start), .MemWrite(MemWrite), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && MemWrite) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", MemAddress, MemWriteData);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", MemAddress, mon_e[63:32]);
        check("wr_data", MemWriteData, mon_e[31:0]);
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_ready", 32'(rx_ready), 1);
    check("rst_hold", 32'(cpu_hold), 1);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_memwrite", 32'(MemWrite), 0);
    check("rst_addr", MemAddress, 0);
    check("rst_data", MemWriteData, 0);
    check("rst_wc", 32'(word_count), 0);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    start    = 1'($urandom_range(0, 1));
    waits    = 0;
    while (!rx_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("FAIL rx_ready_timeout: byte %h never accepted", b);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_done", 32'(done), 0);
    check("start_error", 32'(error), 0);
    check("start_hold", 32'(cpu_hold), 1);
    check("start_ready", 32'(rx_ready), 1);
    check("start_wc", 32'(word_count), 0);
  endtask

  task automatic send_frame(input logic [31:0] words[$], input logic [7:0] chk_flip, input bit gaps);
    int n;
    int w;
    int g;
    int t;
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] bytes[$];
    n = words.size();
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(words[i] >> (24 - 8*j));
        bytes.push_back(b);
        x = x ^ b;
      end
      exp_q.push_back({32'(4*i), words[i]});
    end
`ifdef LOADER_ZERO_FILL_EN
    if (chk_flip == 8'h00)
      for (int a = n; a < 256; a++) exp_q.push_back({32'(4*a), 32'h0});
`endif
    send_byte(8'(n), gaps ? int'($urandom_range(0, 2)) : 0, w);
    check("len_stall", 32'(w), 0);
    for (int k = 0; k < bytes.size(); k++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      send_byte(bytes[k], g, w);
      check("byte_stall", 32'(w), (k % 4 == 0 && k > 0 && g == 0) ? 1 : 0);
    end
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    send_byte(x ^ chk_flip, g, w);
    check("chk_stall", 32'(w), (g == 0) ? 1 : 0);
    rx_valid = 1'b0;
    if (chk_flip == 8'h00) begin
`ifdef LOADER_ZERO_FILL_EN
      check("fill_hold", 32'(cpu_hold), 1);
      t = 0;
      while (!done && t < 600) begin
        @(negedge clk);
        t++;
      end
`endif
      check("good_done", 32'(done), 1);
      check("good_error", 32'(error), 0);
      check("good_hold", 32'(cpu_hold), 0);
      check("good_ready", 32'(rx_ready), 0);
      check("good_wc", 32'(word_count), 32'(n));
    end else begin
      check("bad_error", 32'(error), 1);
      check("bad_done", 32'(done), 0);
      check("bad_hold", 32'(cpu_hold), 1);
      check("bad_wc", 32'(word_count), 32'(n));
    end
  endtask

  initial begin
    logic [31:0] words[$];
    logic [7:0]  part[$];
    int w;
    int n;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    start    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    @(negedge clk);

    words = '{32'h20040003, 32'h0C000003};
    send_frame(words, 8'h00, 1'b0);
    pulse_start();
    send_frame(words, 8'h01, 1'b1);
    pulse_start();

    send_byte(8'h00, 0, w);
    rx_valid = 1'b0;
    check("len0_error", 32'(error), 1);
    check("len0_done", 32'(done), 0);
    check("len0_hold", 32'(cpu_hold), 1);
    pulse_start();
    words = '{32'h12345678};
    send_frame(words, 8'h00, 1'b1);
    pulse_start();

    // Valid held high across word boundaries: stalled byte must not be dropped or shifted
    words = '{32'h11223344, 32'hAB5A0FF0, 32'h00000001};
    send_frame(words, 8'h00, 1'b0);
    pulse_start();

    exp_q.push_back({32'h0, 32'hDEADBEEF});
    part = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h77};
    foreach (part[i]) send_byte(part[i], 0, w);
    reset = 1'b0;
    #1;
    check_reset_vals();
    check("abort_pending", 32'(exp_q.size()), 0);
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    words = '{32'hFFFFFFFF};
    send_frame(words, 8'h00, 1'b0);
    pulse_start();

    for (int f = 0; f < 12; f++) begin
      words.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      send_frame(words, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 1'($urandom_range(0, 1)));
      pulse_start();
    end

    words.delete();
    for (int i = 0; i < 255; i++) words.push_back($urandom);
    send_frame(words, 8'h00, 1'b1);

    repeat (3) @(negedge clk);
    check("leftover_writes", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
